ctrl_redirect_sequencer: RTL and testbench
==========================================

// Module: ctrl_redirect_sequencer
// PURPOSE
//  Recovery sequencer behind the control-transfer ALU in the execute stage.
//  Samples each resolved control instruction (flags, nextPC, age tag) and tracks the oldest mispredict.
//  Runs the recovery sequence: pipeline flush for a fixed number of cycles, then a fetch redirect with a valid/ready handshake.
//  Also keeps a saturating mispredict count for performance monitoring.
// PARAMETERS
//  PC_W          32  width of PC / nextPC
//  AGE_W          7  age tag width: MSB = wrap bit, [AGE_W-2:0] = active-list index
//  FLAGS_W        8  width of execution flags bus; bit0 = mispredict, bit2 = executed
//  FLUSH_CYCLES   2  cycles flush_o is held asserted per recovery (>=1)
//  CNT_W         16  mispredict counter width
// PORTS
//  clk              in   1        clock, all state on rising edge
//  reset            in   1        asynchronous, active-low reset
//  ctrlValid_i      in   1        control ALU result valid this cycle
//  ctrlFlags_i      in   FLAGS_W  execution flags from control ALU
//  ctrlNextPC_i     in   PC_W     resolved next PC from control ALU
//  ctrlAge_i        in   AGE_W    age tag of the resolving instruction
//  fetchReady_i     in   1        fetch accepts redirect this cycle
//  flush_o          out  1        squash younger-than-recoverAge_o work
//  recoverAge_o     out  AGE_W    age tag of mispredict being recovered
//  redirectValid_o  out  1        redirect PC presented to fetch
//  redirectPC_o     out  PC_W     redirect target
//  busy_o           out  1        state != IDLE
//  mispredCount_o   out  CNT_W    saturating count of captured mispredicts
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; flush counter 0.
//  Trigger: misp = ctrlValid_i & ctrlFlags_i[2] & ctrlFlags_i[0].
//  Age compare: A older than B iff (A[MSB]==B[MSB]) ? A[idx]<B[idx] : A[idx]>B[idx]. Equal tags are not older.
//  States:
//   IDLE: misp -> capture nextPC/age; go to FLUSH; flush counter = FLUSH_CYCLES-1.
//   FLUSH: flush_o=1. Counter decrements each cycle; at 0 go to REDIRECT.
//     Total flush_o high = FLUSH_CYCLES cycles, starting the cycle after capture.
//   REDIRECT: redirectValid_o=1. redirectPC_o is stable until the handshake
//     (redirectValid_o & fetchReady_i at the clock edge). After the handshake, go to IDLE next cycle.
//  Preemption, in FLUSH or REDIRECT:
//   misp older than recoverAge_o -> recapture; FLUSH restarts at FLUSH_CYCLES-1.
//   In REDIRECT, a same-cycle handshake still completes, but the next state is FLUSH, not IDLE.
//   misp with an age younger than or equal to recoverAge_o -> dropped (already squashed).
//  Timing: capture-to-first-flush = 1 cycle. Capture-to-redirectValid_o = FLUSH_CYCLES+1 cycles.
//  Outputs are registered. recoverAge_o/redirectPC_o hold their last value in IDLE.
//  mispredCount_o +1 per capture (including preemptions); saturates at 2^CNT_W-1, no wrap.
//  Non-mispredict or !executed results are ignored in all states.
//  Reset mid-sequence: immediate return to IDLE with all outputs 0; no redirect issued.
// TESTING
//  1 Single misp: age 0x05, nextPC 0x400100, fetchReady_i=1
//    -> flush_o high cycles 1-2; redirectValid_o cycle 3 with PC 0x400100; IDLE cycle 4; count=1.
//  2 Backpressure: fetchReady_i=0 for 5 cycles in REDIRECT
//    -> redirectValid_o/PC held stable 5 cycles; completes on the first ready cycle.
//  3 Preempt during FLUSH: capture age 0x10, then age 0x0C misp in cycle 1
//    -> recoverAge_o=0x0C, flush extends to 2 cycles from recapture, count=2.
//  4 Younger/wrap drop: capture age 0x42 (wrap=1, idx 2), misp age 0x3E (wrap=0, idx 62) arrives
//    -> 0x3E is older, preempts; a following misp at 0x43 is dropped.
//  5 Saturation: CNT_W=4, 20 mispredicts -> mispredCount_o stops at 15.
//  6 Async reset asserted in REDIRECT mid-cycle -> all outputs 0 immediately; busy_o=0; no handshake.

Source files
------------

// File: rtl/ctrl_redirect_sequencer.sv
// Mispredict recovery sequencer: tracks the oldest mispredict, flushes,
// then issues a fetch redirect through a valid/ready handshake.
module ctrl_redirect_sequencer #(
  parameter int PC_W         = 32,
  parameter int AGE_W        = 7,
  parameter int FLAGS_W      = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrlValid_i,
  input  logic [FLAGS_W-1:0] ctrlFlags_i,
  input  logic [PC_W-1:0]    ctrlNextPC_i,
  input  logic [AGE_W-1:0]   ctrlAge_i,
  input  logic               fetchReady_i,
  output logic               flush_o,
  output logic [AGE_W-1:0]   recoverAge_o,
  output logic               redirectValid_o,
  output logic [PC_W-1:0]    redirectPC_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   mispredCount_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic              misp;
  logic              capture;
  logic              unused_flags;

  assign unused_flags = ^{ctrlFlags_i[FLAGS_W-1:3], ctrlFlags_i[1]};

  // Wrap bit flips each lap of the active list, inverting index order.
  function automatic logic older(input logic [AGE_W-1:0] a,
                                 input logic [AGE_W-1:0] b);
    if (a[AGE_W-1] == b[AGE_W-1])
      return a[AGE_W-2:0] < b[AGE_W-2:0];
    return a[AGE_W-2:0] > b[AGE_W-2:0];
  endfunction

  always_comb begin
    misp    = ctrlValid_i & ctrlFlags_i[2] & ctrlFlags_i[0];
    capture = misp & ((state_q == IDLE) | older(ctrlAge_i, age_q));
    state_d = state_q;
    cnt_d   = cnt_q;
    age_d   = age_q;
    pc_d    = pc_q;
    num_d   = num_q;
    unique case (state_q)
      IDLE: ;
      FLUSH: begin
        if (cnt_q == '0) state_d = REDIR;
        else             cnt_d   = cnt_q - CW'(1);
      end
      REDIR: begin
        if (fetchReady_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An older mispredict overrides any progress, even a same-cycle handshake.
    if (capture) begin
      state_d = FLUSH;
      cnt_d   = CNT_INIT;
      age_d   = ctrlAge_i;
      pc_d    = ctrlNextPC_i;
      if (num_q != CNT_MAX) num_d = num_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      age_q   <= '0;
      pc_q    <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
      pc_q    <= pc_d;
      num_q   <= num_d;
    end
  end

  assign flush_o         = (state_q == FLUSH);
  assign redirectValid_o = (state_q == REDIR);
  assign busy_o          = (state_q != IDLE);
  assign recoverAge_o    = age_q;
  assign redirectPC_o    = pc_q;
  assign mispredCount_o  = num_q;

endmodule

// File: tb/tb_ctrl_redirect_sequencer.sv
// Bench for ctrl_redirect_sequencer: vector table, corner sequences,
// and random traffic against a timeline-based reference model.
module tb_ctrl_redirect_sequencer;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrlValid_i;
  logic [7:0]  ctrlFlags_i;
  logic [31:0] ctrlNextPC_i;
  logic [6:0]  ctrlAge_i;
  logic        fetchReady_i;
  logic        flush_o;
  logic [6:0]  recoverAge_o;
  logic        redirectValid_o;
  logic [31:0] redirectPC_o;
  logic        busy_o;
  logic [3:0]  mispredCount_o;

  int total = 0;
  int bad   = 0;

  // Reference model: a recovery is a capture timestamp; outputs follow
  // from the distance between the current cycle and that timestamp.
  bit          m_active;
  int          m_cap;
  int          m_cyc;
  logic [6:0]  m_age;
  logic [31:0] m_pc;
  int          m_cnt;

  ctrl_redirect_sequencer #(
    .PC_W(32), .AGE_W(7), .FLAGS_W(8), .FLUSH_CYCLES(FC), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctrlValid_i(ctrlValid_i),
    .ctrlFlags_i(ctrlFlags_i),
    .ctrlNextPC_i(ctrlNextPC_i),
    .ctrlAge_i(ctrlAge_i),
    .fetchReady_i(fetchReady_i),
    .flush_o(flush_o),
    .recoverAge_o(recoverAge_o),
    .redirectValid_o(redirectValid_o),
    .redirectPC_o(redirectPC_o),
    .busy_o(busy_o),
    .mispredCount_o(mispredCount_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic bit m_older(input logic [6:0] a, input logic [6:0] b);
    if (a[6] == b[6]) return a[5:0] < b[5:0];
    return a[5:0] > b[5:0];
  endfunction

  function automatic bit exp_flush();
    return m_active && (m_cyc - m_cap) <= FC;
  endfunction

  function automatic bit exp_rv();
    return m_active && (m_cyc - m_cap) > FC;
  endfunction

  task automatic check_model();
    check("flush", 64'(flush_o), 64'(exp_flush()));
    check("rvalid", 64'(redirectValid_o), 64'(exp_rv()));
    check("busy", 64'(busy_o), 64'(m_active));
    check("age", 64'(recoverAge_o), 64'(m_age));
    check("pc", 64'(redirectPC_o), 64'(m_pc));
    check("count", 64'(mispredCount_o), 64'(m_cnt));
  endtask

  // Drive one cycle of inputs and advance the model across the next edge.
  task automatic apply(input logic v, input logic [7:0] fl,
                       input logic [31:0] pc, input logic [6:0] age,
                       input logic rdy);
    bit hs, misp, cap;
    ctrlValid_i  = v;
    ctrlFlags_i  = fl;
    ctrlNextPC_i = pc;
    ctrlAge_i    = age;
    fetchReady_i = rdy;
    hs   = exp_rv() && rdy;
    misp = v && fl[2] && fl[0];
    cap  = misp && (!m_active || m_older(age, m_age));
    if (cap) begin
      m_active = 1'b1;
      m_cap    = m_cyc;
      m_age    = age;
      m_pc     = pc;
      m_cnt    = (m_cnt < 15) ? m_cnt + 1 : 15;
    end else if (hs) begin
      m_active = 1'b0;
    end
    m_cyc++;
  endtask

  task automatic step(input logic v, input logic [7:0] fl,
                      input logic [31:0] pc, input logic [6:0] age,
                      input logic rdy);
    @(negedge clk);
    check_model();
    apply(v, fl, pc, age, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 32'h0, 7'h0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    ctrlValid_i  = 1'b0;
    ctrlFlags_i  = 8'h00;
    ctrlNextPC_i = 32'h0;
    ctrlAge_i    = 7'h0;
    fetchReady_i = 1'b0;
    m_active = 1'b0;
    m_age    = '0;
    m_pc     = '0;
    m_cnt    = 0;
    m_cap    = 0;
    m_cyc    = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  fl;
    logic [31:0] pc;
    logic [6:0]  age;
    logic        rdy;
    logic        e_fl;
    logic        e_rv;
    logic        e_busy;
    logic [31:0] e_pc;
    logic [6:0]  e_age;
    int          e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 8'h05, 32'h400100, 7'h05, 1, 0, 0, 0, 32'h0, 7'h0, 0};
    tbl[1] = '{0, 8'h00, 32'h0, 7'h0, 1, 1, 0, 1, 32'h400100, 7'h05, 1};
    tbl[2] = '{0, 8'h00, 32'h0, 7'h0, 1, 1, 0, 1, 32'h400100, 7'h05, 1};
    tbl[3] = '{0, 8'h00, 32'h0, 7'h0, 1, 0, 1, 1, 32'h400100, 7'h05, 1};
    tbl[4] = '{1, 8'h01, 32'h999, 7'h01, 1, 0, 0, 0, 32'h400100, 7'h05, 1};
    tbl[5] = '{1, 8'h04, 32'h999, 7'h01, 1, 0, 0, 0, 32'h400100, 7'h05, 1};
    tbl[6] = '{0, 8'h05, 32'h999, 7'h01, 1, 0, 0, 0, 32'h400100, 7'h05, 1};
    tbl[7] = '{1, 8'hFA, 32'h999, 7'h01, 1, 0, 0, 0, 32'h400100, 7'h05, 1};
    tbl[8] = '{0, 8'h00, 32'h0, 7'h0, 1, 0, 0, 0, 32'h400100, 7'h05, 1};

    reset = 1'b1;
    do_reset();

    // Single mispredict plus ignored non-mispredict results.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("tbl%0d_flush", i), 64'(flush_o), 64'(tbl[i].e_fl));
      check($sformatf("tbl%0d_rv", i), 64'(redirectValid_o),
            64'(tbl[i].e_rv));
      check($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_pc", i), 64'(redirectPC_o), 64'(tbl[i].e_pc));
      check($sformatf("tbl%0d_age", i), 64'(recoverAge_o),
            64'(tbl[i].e_age));
      check($sformatf("tbl%0d_cnt", i), 64'(mispredCount_o),
            64'(tbl[i].e_cnt));
      apply(tbl[i].v, tbl[i].fl, tbl[i].pc, tbl[i].age, tbl[i].rdy);
    end

    // Backpressure: five stalled redirect cycles, then accept.
    do_reset();
    step(1'b1, 8'h05, 32'h0000_8000, 7'h05, 1'b0);
    idle(FC, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rv", 64'(redirectValid_o), 64'h1);
      check("bp_pc", 64'(redirectPC_o), 64'h8000);
      apply(1'b0, 8'h00, 32'h0, 7'h0, 1'b0);
    end
    step(1'b0, 8'h00, 32'h0, 7'h0, 1'b1);
    @(negedge clk);
    check("bp_done_busy", 64'(busy_o), 64'h0);
    apply(1'b0, 8'h00, 32'h0, 7'h0, 1'b1);

    // Preempt during flush with an older age.
    do_reset();
    step(1'b1, 8'h05, 32'h1000, 7'h10, 1'b1);
    step(1'b1, 8'h05, 32'h2000, 7'h0C, 1'b1);
    @(negedge clk);
    check("pre_age", 64'(recoverAge_o), 64'h0C);
    check("pre_cnt", 64'(mispredCount_o), 64'h2);
    check("pre_flush", 64'(flush_o), 64'h1);
    apply(1'b0, 8'h00, 32'h0, 7'h0, 1'b1);
    idle(4, 1'b1);

    // Wrap-aware compare: 0x3E older than 0x42, 0x43 dropped.
    do_reset();
    step(1'b1, 8'h05, 32'h3000, 7'h42, 1'b1);
    step(1'b1, 8'h05, 32'h4000, 7'h3E, 1'b1);
    step(1'b1, 8'h05, 32'h5000, 7'h43, 1'b1);
    @(negedge clk);
    check("wrap_age", 64'(recoverAge_o), 64'h3E);
    check("wrap_pc", 64'(redirectPC_o), 64'h4000);
    check("wrap_cnt", 64'(mispredCount_o), 64'h2);
    apply(1'b0, 8'h00, 32'h0, 7'h0, 1'b1);
    idle(4, 1'b1);

    // Saturation: 20 successively older mispredicts.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'h05, 32'(i), 7'(40 - i), 1'b0);
    @(negedge clk);
    check("sat_cnt", 64'(mispredCount_o), 64'hF);
    apply(1'b0, 8'h00, 32'h0, 7'h0, 1'b1);
    idle(4, 1'b1);

    // Async reset while a redirect is waiting on fetch.
    do_reset();
    step(1'b1, 8'h05, 32'h7000, 7'h07, 1'b0);
    idle(FC + 1, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    fetchReady_i = 1'b1;
    #1;
    check("rst_flush", 64'(flush_o), 64'h0);
    check("rst_rv", 64'(redirectValid_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_age", 64'(recoverAge_o), 64'h0);
    check("rst_pc", 64'(redirectPC_o), 64'h0);
    check("rst_cnt", 64'(mispredCount_o), 64'h0);
    do_reset();
    idle(3, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [7:0] fl;
      fl = 8'($urandom);
      if ($urandom_range(0, 2) == 0) fl = fl | 8'h05;
      step(1'($urandom_range(0, 1)), fl, $urandom, 7'($urandom),
           1'($urandom_range(0, 9) < 7));
    end
    @(negedge clk);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
